sequence_multiplier: RTL and testbench

Consumes the gate stream from `sequence_generator` and maintains the running 2x2 complex unitary of the sequence being enumerated. Each transferred gate index is looked up in a fixed gate ROM and left-multiplied onto the accumulated matrix; a `first` gate reloads it. After every gate the block presents the resulting matrix with a one-cycle valid pulse to the downstream comparator stage.

---
 rtl/qc_pkg.sv | 73 +++++++
 rtl/sequence_multiplier_if.sv | 27 ++
 rtl/gate_rom.sv | 25 ++
 rtl/sequence_multiplier.sv | 153 +++++++++++++++
 tb/tb_sequence_multiplier.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qc_pkg.sv
// qc_pkg: shared fixed-point complex types, Q2.14 constants and gate-library contents.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package qc_pkg;

  localparam int CW      = 16;  // component width of cplx_t
  localparam int GATE_W  = 5;   // width of the gate library index
  localparam int FX_FRAC = 14;

  localparam logic signed [CW-1:0] FX_ZERO   = 16'sd0;
  localparam logic signed [CW-1:0] FX_ONE    = 16'sd16384;
  localparam logic signed [CW-1:0] FX_RSQRT2 = 16'sd11585;

  typedef struct packed {
    logic signed [CW-1:0] re;
    logic signed [CW-1:0] im;
  } cplx_t;

  // [row][col]
  typedef cplx_t [1:0][1:0] mat2_t;

  typedef enum logic [GATE_W-1:0] {
    G_I   = 5'd0,
    G_H   = 5'd1,
    G_X   = 5'd2,
    G_S   = 5'd3,
    G_T   = 5'd4,
    G_TDG = 5'd5
  } gate_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_DONE
  } state_e;

  function automatic cplx_t cx(input logic signed [CW-1:0] re, input logic signed [CW-1:0] im);
    cplx_t z;
    z.re = re;
    z.im = im;
    return z;
  endfunction

  // Unlisted indices (0 and 6..31) are the identity.
  function automatic mat2_t gate_mat(input logic [GATE_W-1:0] g);
    mat2_t m;
    m[0][0] = cx(FX_ONE, FX_ZERO);
    m[0][1] = cx(FX_ZERO, FX_ZERO);
    m[1][0] = cx(FX_ZERO, FX_ZERO);
    m[1][1] = cx(FX_ONE, FX_ZERO);
    case (gate_e'(g))
      G_H: begin
        m[0][0] = cx(FX_RSQRT2, FX_ZERO);
        m[0][1] = cx(FX_RSQRT2, FX_ZERO);
        m[1][0] = cx(FX_RSQRT2, FX_ZERO);
        m[1][1] = cx(-FX_RSQRT2, FX_ZERO);
      end
      G_X: begin
        m[0][0] = cx(FX_ZERO, FX_ZERO);
        m[0][1] = cx(FX_ONE, FX_ZERO);
        m[1][0] = cx(FX_ONE, FX_ZERO);
        m[1][1] = cx(FX_ZERO, FX_ZERO);
      end
      G_S:   m[1][1] = cx(FX_ZERO, FX_ONE);
      G_T:   m[1][1] = cx(FX_RSQRT2, FX_RSQRT2);
      G_TDG: m[1][1] = cx(FX_RSQRT2, -FX_RSQRT2);
      default: ;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sequence_multiplier_if.sv
// sequence_multiplier_if: gate stream in, accumulated matrix out.
// Latency: none (wires only).
// Backpressure: producer holds ready; a transfer happens only while available is high.
interface sequence_multiplier_if #(
  parameter int W         = 16,
  parameter int GATE_BITS = 5
);
  logic [4:0]           seq_index;
  logic [GATE_BITS-1:0] seq_gate;
  logic                 first;
  logic                 ready;
  logic                 available;
  logic [3:0][W-1:0]    result_re;     // [0]=m00 [1]=m01 [2]=m10 [3]=m11
  logic [3:0][W-1:0]    result_im;
  logic [4:0]           result_index;
  logic                 result_valid;

  modport master (
    output seq_index, seq_gate, first, ready,
    input  available, result_re, result_im, result_index, result_valid
  );

  modport slave (
    input  seq_index, seq_gate, first, ready,
    output available, result_re, result_im, result_index, result_valid
  );
endinterface

// File: rtl/gate_rom.sv
// gate_rom: fixed 2x2 gate library, synchronous read.
// Latency: 1 cycle from rd_en edge to g.
// Backpressure: none; g holds its value while rd_en is low.
module gate_rom
  import qc_pkg::*;
#(
  parameter int GATE_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_en,
  input  logic [GATE_BITS-1:0] idx,
  output mat2_t                g
);

  // Registered lookup; held between reads so the MAC sees a stable G.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g <= '0;
    end else if (rd_en) begin
      g <= gate_mat(GATE_W'(idx));
    end
  end

endmodule

// File: rtl/sequence_multiplier.sv
// sequence_multiplier: accumulates A = G x A over the gate stream with one complex MAC.
// Latency: first gate 2 cycles transfer->result_valid, other gates 10 cycles.
// Backpressure: available only in IDLE; ready while busy is ignored.
module sequence_multiplier
  import qc_pkg::*;
#(
  parameter int W         = 16,  // must equal qc_pkg::CW
  parameter int GATE_BITS = 5
) (
  input logic                  clk,
  input logic                  reset,
  sequence_multiplier_if.slave sm
);

  localparam int AW = 2*W + 2;
  localparam logic signed [AW-1:0] RND  = AW'(2**(FX_FRAC-1));
  localparam logic signed [AW-1:0] MAXV = AW'(2**(W-1) - 1);
  localparam logic signed [AW-1:0] MINV = -AW'(2**(W-1));

  state_e state, state_nxt;
  logic   available_c, result_valid_c, xfer;

  logic [2:0] k;          // MAC step: {row, col, term}
  logic [4:0] idx_q;
  logic [4:0] res_idx;
  logic       first_q;

  mat2_t g_mat, a_mat, n_mat, n_next;
  cplx_t gm, am, elem;
  logic  t, r, c;

  logic signed [2*W-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [AW-1:0]  acc_re, acc_im, sum_re, sum_im;

  // Q4.28 sum back to Q2.14: round half up, then clamp to the W-bit range.
  function automatic logic signed [W-1:0] rnd_sat(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] s;
    s = (v + RND) >>> FX_FRAC;
    if (s > MAXV)      return {1'b0, {(W-1){1'b1}}};
    else if (s < MINV) return {1'b1, {(W-1){1'b0}}};
    else               return s[W-1:0];
  endfunction

  // ROM is read on the transfer edge so G is already valid during LOAD.
  gate_rom #(.GATE_BITS(GATE_BITS)) u_rom (
    .clk   (clk),
    .reset (reset),
    .rd_en (xfer),
    .idx   (sm.seq_gate),
    .g     (g_mat)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt      = state;
    available_c    = 1'b0;
    result_valid_c = 1'b0;
    case (state)
      S_IDLE: begin
        available_c = 1'b1;
        if (sm.ready) state_nxt = S_LOAD;
      end
      S_LOAD:  state_nxt = first_q ? S_DONE : S_MUL;
      S_MUL:   if (k == 3'd7) state_nxt = S_DONE;
      S_DONE: begin
        result_valid_c = 1'b1;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign xfer = available_c && sm.ready;

  // One complex multiply-accumulate term per cycle: acc += G[r][t] * A[t][c].
  always_comb begin
    t    = k[0];
    c    = k[1];
    r    = k[2];
    gm   = g_mat[r][t];
    am   = a_mat[t][c];
    p_rr = (2*W)'(gm.re) * (2*W)'(am.re);
    p_ii = (2*W)'(gm.im) * (2*W)'(am.im);
    p_ri = (2*W)'(gm.re) * (2*W)'(am.im);
    p_ir = (2*W)'(gm.im) * (2*W)'(am.re);
    sum_re  = acc_re + AW'(p_rr) - AW'(p_ii);
    sum_im  = acc_im + AW'(p_ri) + AW'(p_ir);
    elem.re = rnd_sat(sum_re);
    elem.im = rnd_sat(sum_im);
    n_next       = n_mat;
    n_next[r][c] = elem;
  end

  // Capture, step counter, accumulator and matrix registers.
  // A is written on the edge into DONE so the valid pulse sees the new matrix.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      first_q <= 1'b0;
      k       <= '0;
      acc_re  <= '0;
      acc_im  <= '0;
      n_mat   <= '0;
      a_mat   <= '0;
      res_idx <= '0;
    end else begin
      if (xfer) begin
        idx_q   <= sm.seq_index;
        first_q <= sm.first;
      end
      case (state)
        S_LOAD: begin
          k      <= '0;
          acc_re <= '0;
          acc_im <= '0;
          if (first_q) begin
            a_mat   <= g_mat;
            res_idx <= idx_q;
          end
        end
        S_MUL: begin
          k <= k + 3'd1;
          if (!t) begin
            acc_re <= sum_re;
            acc_im <= sum_im;
          end else begin
            acc_re <= '0;
            acc_im <= '0;
            n_mat  <= n_next;
            if (k == 3'd7) begin
              a_mat   <= n_next;
              res_idx <= idx_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sm.available    = available_c;
  assign sm.result_valid = result_valid_c;
  assign sm.result_index = res_idx;
  assign sm.result_re    = {a_mat[1][1].re, a_mat[1][0].re, a_mat[0][1].re, a_mat[0][0].re};
  assign sm.result_im    = {a_mat[1][1].im, a_mat[1][0].im, a_mat[0][1].im, a_mat[0][0].im};

endmodule

// File: tb/tb_sequence_multiplier.sv
// tb_sequence_multiplier: directed and randomized checks of sequence_multiplier.
// Latency: expects 2 cycles for first gates, 10 otherwise.
// Backpressure: exercises ready held high while the block is busy.
module tb_sequence_multiplier;

  localparam int W   = 16;
  localparam int GB  = 5;
  localparam int RS2 = 11585;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sequence_multiplier_if #(.W(W), .GATE_BITS(GB)) sm ();

  sequence_multiplier #(.W(W), .GATE_BITS(GB)) dut (
    .clk   (clk),
    .reset (reset),
    .sm    (sm)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  // Reference matrix, element order m00, m01, m10, m11.
  int mre[4];
  int mim[4];

  int q_cyc[$];
  int q_idx[$];
  int q_re[$];
  int q_im[$];

  function automatic longint rs(input longint v);
    longint s;
    s = (v + 64'sd8192) >>> 14;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  // Matrix product G x A on plain integers.
  task automatic model_apply(input bit f, input int g);
    int gr[4], gi[4], nr[4], ni[4];
    longint sr, si;
    gr = '{16384, 0, 0, 16384};
    gi = '{0, 0, 0, 0};
    case (g)
      1: gr = '{RS2, RS2, RS2, -RS2};
      2: gr = '{0, 16384, 16384, 0};
      3: begin gr = '{16384, 0, 0, 0};   gi = '{0, 0, 0, 16384}; end
      4: begin gr = '{16384, 0, 0, RS2}; gi = '{0, 0, 0, RS2};   end
      5: begin gr = '{16384, 0, 0, RS2}; gi = '{0, 0, 0, -RS2};  end
      default: ;
    endcase
    if (f) begin
      mre = gr;
      mim = gi;
    end else begin
      for (int r = 0; r < 2; r++) begin
        for (int c = 0; c < 2; c++) begin
          sr = 0;
          si = 0;
          for (int t = 0; t < 2; t++) begin
            sr += longint'(gr[2*r+t]) * mre[2*t+c] - longint'(gi[2*r+t]) * mim[2*t+c];
            si += longint'(gr[2*r+t]) * mim[2*t+c] + longint'(gi[2*r+t]) * mre[2*t+c];
          end
          nr[2*r+c] = int'(rs(sr));
          ni[2*r+c] = int'(rs(si));
        end
      end
      mre = nr;
      mim = ni;
    end
  endtask

  // Waits for available, transfers one gate, returns cycles until result_valid (-1 on timeout).
  task automatic send(input bit f, input int g, input int idx, output int lat);
    int n;
    n = 0;
    while (sm.available !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    sm.ready     = 1'b1;
    sm.first     = f;
    sm.seq_gate  = 5'(g);
    sm.seq_index = 5'(idx);
    @(posedge clk); #1;
    sm.ready     = 1'b0;
    sm.first     = 1'($urandom);
    sm.seq_gate  = 5'($urandom);
    sm.seq_index = 5'($urandom);
    model_apply(f, g);
    lat = -1;
    for (int i = 1; i <= 16; i++) begin
      if (sm.result_valid === 1'b1) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    sm.ready     = 1'b0;
    sm.first     = 1'b0;
    sm.seq_gate  = '0;
    sm.seq_index = '0;
    mre = '{0, 0, 0, 0};
    mim = '{0, 0, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sm.available !== 1'b1) begin failures++; $display("FAIL reset_available: got %b expected 1", sm.available); end
    checks++;
    if (sm.result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", sm.result_valid); end
    checks++;
    if (sm.result_re !== '0 || sm.result_im !== '0) begin failures++; $display("FAIL reset_result: got re=%h im=%h expected 0", sm.result_re, sm.result_im); end
    checks++;
    if (sm.result_index !== 5'd0) begin failures++; $display("FAIL reset_index: got %0d expected 0", sm.result_index); end
  endtask

  task automatic test_first_h();
    int lat;
    int er[4];
    send(1'b1, 1, 0, lat);
    er = '{RS2, RS2, RS2, -RS2};
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL first_h_latency: got %0d expected 2", lat); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ($signed(sm.result_re[i]) !== er[i]) begin failures++; $display("FAIL first_h_re[%0d]: got %0d expected %0d", i, $signed(sm.result_re[i]), er[i]); end
      checks++;
      if ($signed(sm.result_im[i]) !== 0) begin failures++; $display("FAIL first_h_im[%0d]: got %0d expected 0", i, $signed(sm.result_im[i])); end
    end
    checks++;
    if (sm.result_index !== 5'd0) begin failures++; $display("FAIL first_h_index: got %0d expected 0", sm.result_index); end
  endtask

  task automatic test_h_h();
    int lat;
    int er[4];
    send(1'b1, 1, 0, lat);
    send(1'b0, 1, 1, lat);
    er = '{16383, 0, 0, 16383};
    checks++;
    if (lat !== 10) begin failures++; $display("FAIL hh_latency: got %0d expected 10", lat); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ($signed(sm.result_re[i]) !== er[i]) begin failures++; $display("FAIL hh_re[%0d]: got %0d expected %0d", i, $signed(sm.result_re[i]), er[i]); end
      checks++;
      if ($signed(sm.result_im[i]) !== 0) begin failures++; $display("FAIL hh_im[%0d]: got %0d expected 0", i, $signed(sm.result_im[i])); end
    end
    checks++;
    if (sm.result_index !== 5'd1) begin failures++; $display("FAIL hh_index: got %0d expected 1", sm.result_index); end
  endtask

  task automatic test_t_t();
    int lat;
    int er[4], ei[4];
    send(1'b1, 4, 2, lat);
    send(1'b0, 4, 3, lat);
    er = '{16384, 0, 0, 0};
    ei = '{0, 0, 0, 16383};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ($signed(sm.result_re[i]) !== er[i]) begin failures++; $display("FAIL tt_re[%0d]: got %0d expected %0d", i, $signed(sm.result_re[i]), er[i]); end
      checks++;
      if ($signed(sm.result_im[i]) !== ei[i]) begin failures++; $display("FAIL tt_im[%0d]: got %0d expected %0d", i, $signed(sm.result_im[i]), ei[i]); end
    end
  endtask

  task automatic test_x_i_s();
    int lat;
    int er[4], ei[4];
    send(1'b1, 2, 4, lat);
    send(1'b0, 31, 5, lat);
    er = '{0, 16384, 16384, 0};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ($signed(sm.result_re[i]) !== er[i]) begin failures++; $display("FAIL xi_re[%0d]: got %0d expected %0d", i, $signed(sm.result_re[i]), er[i]); end
    end
    send(1'b0, 3, 6, lat);
    er = '{0, 16384, 0, 0};
    ei = '{0, 0, 16384, 0};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ($signed(sm.result_re[i]) !== er[i]) begin failures++; $display("FAIL xis_re[%0d]: got %0d expected %0d", i, $signed(sm.result_re[i]), er[i]); end
      checks++;
      if ($signed(sm.result_im[i]) !== ei[i]) begin failures++; $display("FAIL xis_im[%0d]: got %0d expected %0d", i, $signed(sm.result_im[i]), ei[i]); end
    end
    checks++;
    if (sm.result_index !== 5'd6) begin failures++; $display("FAIL xis_index: got %0d expected 6", sm.result_index); end
  endtask

  task automatic test_random();
    int lat, g, idx;
    bit f;
    for (int n = 0; n < 25; n++) begin
      f   = (n == 0) || ($urandom_range(0, 4) == 0);
      g   = ($urandom_range(0, 7) == 7) ? $urandom_range(6, 31) : $urandom_range(0, 5);
      idx = $urandom_range(0, 31);
      send(f, g, idx, lat);
      checks++;
      if (lat !== (f ? 2 : 10)) begin failures++; $display("FAIL rand_latency #%0d: got %0d expected %0d", n, lat, f ? 2 : 10); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ($signed(sm.result_re[i]) !== mre[i]) begin failures++; $display("FAIL rand_re[%0d] #%0d: got %0d expected %0d", i, n, $signed(sm.result_re[i]), mre[i]); end
        checks++;
        if ($signed(sm.result_im[i]) !== mim[i]) begin failures++; $display("FAIL rand_im[%0d] #%0d: got %0d expected %0d", i, n, $signed(sm.result_im[i]), mim[i]); end
      end
      checks++;
      if (sm.result_index !== 5'(idx)) begin failures++; $display("FAIL rand_index #%0d: got %0d expected %0d", n, sm.result_index, idx); end
    end
  endtask

  task automatic test_reset_mid_mul();
    int n;
    n = 0;
    while (sm.available !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    sm.ready     = 1'b1;
    sm.first     = 1'b0;
    sm.seq_gate  = 5'd1;
    sm.seq_index = 5'd7;
    @(posedge clk); #1;
    sm.ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (sm.available !== 1'b1) begin failures++; $display("FAIL midreset_available: got %b expected 1", sm.available); end
    checks++;
    if (sm.result_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid: got %b expected 0", sm.result_valid); end
    checks++;
    if (sm.result_re !== '0 || sm.result_im !== '0) begin failures++; $display("FAIL midreset_result: got re=%h im=%h expected 0", sm.result_re, sm.result_im); end
    checks++;
    if (sm.result_index !== 5'd0) begin failures++; $display("FAIL midreset_index: got %0d expected 0", sm.result_index); end
    @(posedge clk); #1;
    reset = 1'b1;
    mre = '{0, 0, 0, 0};
    mim = '{0, 0, 0, 0};
    n = 0;
    repeat (14) begin
      @(posedge clk); #1;
      if (sm.result_valid === 1'b1) n++;
    end
    checks++;
    if (n !== 0) begin failures++; $display("FAIL midreset_pulses: got %0d expected 0", n); end
  endtask

  // A non-first gate straight after reset multiplies into the zero matrix.
  task automatic test_zero_after_reset();
    int lat;
    send(1'b0, 1, 9, lat);
    checks++;
    if (lat !== 10) begin failures++; $display("FAIL zero_latency: got %0d expected 10", lat); end
    checks++;
    if (sm.result_re !== '0 || sm.result_im !== '0) begin failures++; $display("FAIL zero_result: got re=%h im=%h expected 0", sm.result_re, sm.result_im); end
    checks++;
    if (sm.result_index !== 5'd9) begin failures++; $display("FAIL zero_index: got %0d expected 9", sm.result_index); end
  endtask

  task automatic test_back_to_back();
    int transfers, pulses, ec, ei, er, eim, g, idx;
    bit f, prev_rv;
    transfers = 0;
    pulses    = 0;
    prev_rv   = 1'b0;
    for (int i = 0; i < 20 && sm.available !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    for (int cy = 0; cy < 165; cy++) begin
      if (sm.result_valid === 1'b1) begin
        pulses++;
        checks++;
        if (prev_rv) begin failures++; $display("FAIL b2b_consecutive_valid: got 2 pulses in a row at cycle %0d expected 1", cyc); end
        if (q_cyc.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b2b_unexpected_pulse: got pulse at cycle %0d expected none", cyc);
        end else begin
          ec = q_cyc.pop_front();
          ei = q_idx.pop_front();
          checks++;
          if (cyc !== ec) begin failures++; $display("FAIL b2b_pulse_cycle: got %0d expected %0d", cyc, ec); end
          checks++;
          if (sm.result_index !== 5'(ei)) begin failures++; $display("FAIL b2b_index: got %0d expected %0d", sm.result_index, ei); end
          for (int i = 0; i < 4; i++) begin
            er  = q_re.pop_front();
            eim = q_im.pop_front();
            checks++;
            if ($signed(sm.result_re[i]) !== er) begin failures++; $display("FAIL b2b_re[%0d]: got %0d expected %0d", i, $signed(sm.result_re[i]), er); end
            checks++;
            if ($signed(sm.result_im[i]) !== eim) begin failures++; $display("FAIL b2b_im[%0d]: got %0d expected %0d", i, $signed(sm.result_im[i]), eim); end
          end
        end
      end
      prev_rv = (sm.result_valid === 1'b1);
      f   = ($urandom_range(0, 2) == 0);
      g   = $urandom_range(0, 7);
      idx = $urandom_range(0, 31);
      sm.ready     = (cy < 150);
      sm.first     = f;
      sm.seq_gate  = 5'(g);
      sm.seq_index = 5'(idx);
      if (sm.ready === 1'b1 && sm.available === 1'b1) begin
        transfers++;
        model_apply(f, g);
        q_cyc.push_back(cyc + (f ? 2 : 10));
        q_idx.push_back(idx);
        for (int i = 0; i < 4; i++) begin
          q_re.push_back(mre[i]);
          q_im.push_back(mim[i]);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (q_cyc.size() !== 0) begin failures++; $display("FAIL b2b_missing_pulses: got %0d outstanding expected 0", q_cyc.size()); end
    checks++;
    if (pulses !== transfers) begin failures++; $display("FAIL b2b_pulse_count: got %0d expected %0d", pulses, transfers); end
    checks++;
    if (transfers < 10) begin failures++; $display("FAIL b2b_transfer_count: got %0d expected at least 10", transfers); end
  endtask

  initial begin
    test_reset();
    test_first_h();
    test_h_h();
    test_t_t();
    test_x_i_s();
    test_random();
    test_reset_mid_mul();
    test_zero_after_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
